// File: rtl/uart_pkg.sv
// Shared definitions for the UART0 sout receiver: frame constants and FSM states.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam int   UART_MIN_DIV   = 4;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO for received characters. The head entry is always visible
// on dout; a push into a full FIFO is accepted when a pop happens in the
// same cycle, because the pop frees the slot the push writes into.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  logic [AW:0]               wptr_q;
  logic [AW:0]               rptr_q;
  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem_q[rptr_q[AW-1:0]];

  // Storage and pointer update; the array is cleared so dout reads 0 after reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= din;
        wptr_q                <= wptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_sout_rx.sv
// 8N1 receiver for the UART0 transmit pad. Synchronizes the line, samples
// each bit mid-period with a down-counting bit timer, buffers bytes in a
// FIFO and reports framing errors, overruns and false start bits.
module uart_sout_rx
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      rx_en,
  input  logic [DIV_W-1:0]          baud_div,
  input  logic                      uart_sin,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      glitch,
  output logic                      busy
);

  localparam int               IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(UART_MIN_DIV);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      s_in;
  logic                      s_next;
  logic                      fall;
  logic [DIV_W-1:0]          d_eff;
  logic                      tick;

  uart_state_e               state_q, state_d;
  logic [DIV_W-1:0]          cnt_q, cnt_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      glitch_q, glitch_d;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      room;

  // Line synchronizer; resets to the idle level so no false start after reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= {SYNC_STAGES{UART_IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_sin};
    end
  end

  // The start edge is seen as it moves into s_in, so START is entered on the
  // same clock edge that s_in goes low.
  assign s_in   = sync_q[SYNC_STAGES-1];
  assign s_next = sync_q[SYNC_STAGES-2];
  assign fall   = s_in && !s_next;

  // Divisors below the minimum would leave no room for a mid-bit sample.
  assign d_eff = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
  // Counter runs from reload-1 down to 0, so a reload of N gives a tick N edges later.
  assign tick  = (cnt_q == '0);

  assign fifo_pop = rx_valid && rx_ready;
  assign room     = !fifo_full || rx_ready;

  // Next-state logic for the frame FSM, bit timer and shift register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    fifo_push   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    glitch_d    = 1'b0;
    if (!rx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d = ST_START;
            div_d   = d_eff;
            cnt_d   = (d_eff >> 1) - DIV_ONE;
          end
        end
        ST_START: begin
          if (tick) begin
            if (!s_in) begin
              state_d = ST_DATA;
              idx_d   = '0;
              cnt_d   = div_q - DIV_ONE;
            end else begin
              glitch_d = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - DIV_ONE;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_d = {s_in, shift_q[UART_DATA_BITS-1:1]};
            cnt_d   = div_q - DIV_ONE;
            idx_d   = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q - DIV_ONE;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (s_in) begin
              if (room) begin
                fifo_push = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            cnt_d = cnt_q - DIV_ONE;
          end
        end
        ST_BREAK: begin
          if (s_in) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, timer, shift register and status pulse registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      glitch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      glitch_q    <= glitch_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (shift_q),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign glitch    = glitch_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_sout_rx.sv
// Bench for uart_sout_rx: directed frames plus randomized traffic compared
// against an expected-byte list built from the 8N1 framing rules.
module tb_uart_sout_rx;

  localparam int DIV_W = 16;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             rx_en;
  logic [DIV_W-1:0] baud_div;
  logic             uart_sin;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             frame_err;
  logic             overrun;
  logic             glitch;
  logic             busy;

  always #5 clk = ~clk;

  uart_sout_rx #(
    .DIV_W       (DIV_W),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .rx_en     (rx_en),
    .baud_div  (baud_div),
    .uart_sin  (uart_sin),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .glitch    (glitch),
    .busy      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: counts pulses, records accepted bytes and valid timing.
  int         n_ferr = 0, n_ovr = 0, n_gl = 0, n_excl = 0, n_vcyc = 0;
  int         rise_cyc = 0, ovr_cyc = 0, ferr_cyc = 0, got_n = 0;
  logic       prev_v = 1'b0;
  logic [7:0] got_mem [0:255];

  always @(negedge clk) begin
    if (rst_b) begin
      if (frame_err) begin n_ferr <= n_ferr + 1; ferr_cyc <= cyc; end
      if (overrun)   begin n_ovr  <= n_ovr + 1;  ovr_cyc  <= cyc; end
      if (glitch)    n_gl <= n_gl + 1;
      if ((int'(frame_err) + int'(overrun) + int'(glitch)) > 1) n_excl <= n_excl + 1;
      if (rx_valid) n_vcyc <= n_vcyc + 1;
      if (rx_valid && !prev_v) rise_cyc <= cyc;
      if (rx_valid && rx_ready && got_n < 256) begin
        got_mem[got_n] <= rx_data;
        got_n          <= got_n + 1;
      end
      prev_v <= rx_valid;
    end else begin
      prev_v <= 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;
  int rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Effective bit period as the receiver interprets baud_div.
  function automatic int eff(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  // Cycles from the start bit hitting uart_sin to the stop-sample result showing.
  function automatic int stop_lat(input int d);
    return SYNC + eff(d) / 2 + 9 * eff(d);
  endfunction

  task automatic send_frame(input logic [7:0] b, input int d, input logic stop_v, output int t0);
    t0       = cyc;
    uart_sin = 1'b0;
    cyc_wait(d);
    for (int i = 0; i < 8; i++) begin
      uart_sin = b[i];
      cyc_wait(d);
    end
    uart_sin = stop_v;
    cyc_wait(d);
  endtask

  task automatic wait_got(input int n, input int limit);
    int k;
    k = 0;
    while (got_n < n && k < limit) begin
      cyc_wait(1);
      k++;
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    if (rd < 256) check(tag, got_mem[rd], exp);
    else          check(tag, 32'hFFFF_FFFF, exp);
    rd++;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0, t5, f0, o0, g0, v0, gn0, k;
    logic [7:0] burst [5];
    logic [7:0] exp_q [$];
    int         div;
    logic [7:0] b;

    rst_b    = 1'b0;
    rx_en    = 1'b1;
    rx_ready = 1'b0;
    uart_sin = 1'b1;
    baud_div = 16'd16;
    cyc_wait(3);
    check("rst_busy_in", busy, 0);
    check("rst_valid_in", rx_valid, 0);
    rst_b = 1'b1;
    cyc_wait(3);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_pulses", {frame_err, overrun, glitch}, 0);
    check("rst_busy", busy, 0);

    // Basic frame with exact latency and one-cycle valid.
    rx_ready = 1'b1;
    f0 = n_ferr; o0 = n_ovr; g0 = n_gl; v0 = n_vcyc; gn0 = got_n; rd = got_n;
    send_frame(8'h55, 16, 1'b1, t0);
    cyc_wait(12);
    check("basic_count", got_n - gn0, 1);
    expect_byte("basic_byte", 8'h55);
    check("basic_latency", rise_cyc - t0, stop_lat(16));
    check("basic_valid_cycles", n_vcyc - v0, 1);
    check("basic_pulses", (n_ferr - f0) + (n_ovr - o0) + (n_gl - g0), 0);

    // Back-to-back fill and overrun.
    rx_ready = 1'b0;
    baud_div = 16'd8;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'hA5; burst[3] = 8'h3C; burst[4] = 8'h81;
    f0 = n_ferr; o0 = n_ovr; gn0 = got_n; rd = got_n;
    for (int i = 0; i < 5; i++) begin
      send_frame(burst[i], 8, 1'b1, t0);
      if (i == 4) t5 = t0;
    end
    cyc_wait(10);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_time", ovr_cyc - t5, stop_lat(8));
    check("ovr_ferr", n_ferr - f0, 0);
    check("ovr_valid", rx_valid, 1);
    check("ovr_head", rx_data, 8'h00);
    check("ovr_no_pop", got_n - gn0, 0);
    rx_ready = 1'b1;
    wait_got(gn0 + DEPTH, 50);
    cyc_wait(3);
    check("ovr_drain_count", got_n - gn0, DEPTH);
    for (int i = 0; i < DEPTH; i++) expect_byte("ovr_drain_byte", burst[i]);
    check("ovr_empty", rx_valid, 0);

    // Framing error followed by a held-low line.
    baud_div = 16'd16;
    f0 = n_ferr; o0 = n_ovr; g0 = n_gl; gn0 = got_n;
    send_frame(8'h12, 16, 1'b0, t0);
    cyc_wait(40 * 16);
    check("ferr_count", n_ferr - f0, 1);
    check("ferr_time", ferr_cyc - t0, stop_lat(16));
    check("ferr_no_push", got_n - gn0, 0);
    check("ferr_busy_break", busy, 1);
    check("ferr_other", (n_ovr - o0) + (n_gl - g0), 0);
    uart_sin = 1'b1;
    cyc_wait(6);
    check("ferr_busy_released", busy, 0);
    check("ferr_no_more", n_ferr - f0, 1);

    // Short low pulse is rejected as a glitch.
    g0 = n_gl; f0 = n_ferr; gn0 = got_n;
    uart_sin = 1'b0;
    cyc_wait(3);
    uart_sin = 1'b1;
    cyc_wait(3);
    check("glitch_busy_start", busy, 1);
    cyc_wait(20);
    check("glitch_count", n_gl - g0, 1);
    check("glitch_idle", busy, 0);
    check("glitch_fifo_empty", rx_valid, 0);
    check("glitch_other", (n_ferr - f0) + (got_n - gn0), 0);

    // Full FIFO with a pop in the stop-sample cycle.
    rx_ready = 1'b0;
    baud_div = 16'd8;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
    o0 = n_ovr; gn0 = got_n; rd = got_n;
    for (int i = 0; i < 4; i++) send_frame(burst[i], 8, 1'b1, t0);
    cyc_wait(4);
    check("simul_full_valid", rx_valid, 1);
    fork
      send_frame(8'h7E, 8, 1'b1, t0);
      begin
        cyc_wait(stop_lat(8) - 1);
        rx_ready = 1'b1;
        cyc_wait(1);
        rx_ready = 1'b0;
      end
    join
    cyc_wait(4);
    check("simul_no_ovr", n_ovr - o0, 0);
    check("simul_one_pop", got_n - gn0, 1);
    expect_byte("simul_pop_byte", 8'h11);
    rx_ready = 1'b1;
    wait_got(gn0 + 5, 50);
    check("simul_occupancy", got_n - gn0, 5);
    expect_byte("simul_b1", 8'h22);
    expect_byte("simul_b2", 8'h33);
    expect_byte("simul_b3", 8'h44);
    expect_byte("simul_last", 8'h7E);

    // rx_en dropped mid-frame keeps FIFO contents.
    rx_ready = 1'b0;
    baud_div = 16'd16;
    gn0 = got_n; rd = got_n;
    send_frame(8'h99, 16, 1'b1, t0);
    cyc_wait(4);
    f0 = n_ferr; o0 = n_ovr; g0 = n_gl;
    fork
      send_frame(8'hC3, 16, 1'b1, t0);
      begin
        cyc_wait(SYNC + 8 + 3 * 16 + 5);
        rx_en = 1'b0;
        cyc_wait(2);
        check("abort_busy", busy, 0);
      end
    join
    cyc_wait(10);
    check("abort_pulses", (n_ferr - f0) + (n_ovr - o0) + (n_gl - g0), 0);
    check("abort_kept_valid", rx_valid, 1);
    check("abort_kept_data", rx_data, 8'h99);
    rx_en = 1'b1;
    cyc_wait(5);
    rx_ready = 1'b1;
    wait_got(gn0 + 1, 20);
    cyc_wait(3);
    check("abort_drain_count", got_n - gn0, 1);
    expect_byte("abort_drain_byte", 8'h99);

    // Asynchronous reset in the middle of a frame.
    gn0 = got_n;
    fork
      send_frame(8'h5A, 16, 1'b1, t0);
      begin
        cyc_wait(60);
        check("arst_busy_before", busy, 1);
        rst_b = 1'b0;
        #1;
        check("arst_busy_now", busy, 0);
        check("arst_outputs_now", {rx_data, rx_valid, frame_err, overrun, glitch}, 0);
      end
    join
    cyc_wait(5);
    rst_b = 1'b1;
    cyc_wait(5);
    check("arst_outputs_after", {rx_data, rx_valid, frame_err, overrun, glitch, busy}, 0);
    check("arst_no_push", got_n - gn0, 0);

    // Randomized frames, divisors and consumer backpressure.
    f0 = n_ferr; o0 = n_ovr; g0 = n_gl; gn0 = got_n; rd = got_n;
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b   = 8'($urandom);
      div = int'($urandom_range(0, 24));
      baud_div = DIV_W'(div);
      cyc_wait(int'($urandom_range(0, 12)));
      exp_q.push_back(b);
      fork
        send_frame(b, eff(div), 1'b1, t0);
        begin
          cyc_wait(20);
          baud_div = DIV_W'($urandom_range(0, 40));
        end
      join
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    wait_got(gn0 + exp_q.size(), 200);
    cyc_wait(3);
    check("rand_count", got_n - gn0, exp_q.size());
    k = exp_q.size();
    for (int i = 0; i < k; i++) expect_byte("rand_byte", exp_q[i]);
    check("rand_pulses", (n_ferr - f0) + (n_ovr - o0) + (n_gl - g0), 0);
    check("pulse_exclusive", n_excl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
